mem_io_responder: RTL and testbench

//  Bus responder on the far end of the CPU's byte-wide memory port (addr, wr, dout -> din).

---
 rtl/mem_io_responder_if.sv | 19 +
 rtl/mem_io_responder.sv | 128 ++++++++++++
 tb/tb_mem_io_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory port: address/write/data from the CPU, read data and
// run/freeze back from the responder.
interface mem_io_responder_if;
  logic [31:0] mem_a_in;
  logic        mem_wr_in;
  logic [7:0]  mem_dout_in;
  logic [7:0]  mem_din_out;
  logic        rdy_out;

  modport master (
    output mem_a_in, mem_wr_in, mem_dout_in,
    input  mem_din_out, rdy_out
  );

  modport slave (
    input  mem_a_in, mem_wr_in, mem_dout_in,
    output mem_din_out, rdy_out
  );
endinterface

// File: rtl/mem_io_responder.sv
// Far-end responder for the CPU memory port: byte RAM plus an I/O page with
// console RX/TX FIFOs, a free-running cycle counter and a sticky stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_valid_in,
  output logic              rx_ready_out,
  output logic [7:0]        tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,
  output logic              prog_stop_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [15:0] IO_DATA = 16'h0000;
  localparam logic [15:0] IO_CNT0 = 16'h0004;
  localparam logic [15:0] IO_CNT1 = 16'h0005;
  localparam logic [15:0] IO_CNT2 = 16'h0006;
  localparam logic [15:0] IO_CNT3 = 16'h0007;

  logic [7:0] ram   [2**RAM_ADDR_W];
  logic [7:0] rxMem [FIFO_DEPTH];
  logic [7:0] txMem [FIFO_DEPTH];

  logic [PTR_W-1:0] rxRdPtr, rxWrPtr, txRdPtr, txWrPtr;
  logic [CNT_W-1:0] rxCount, txCount, rxCountNext, txCountNext;
  logic [31:0]      cycleCnt, cntSnap;
  logic [7:0]       memDinReg, readData, txPushData;
  logic             rdyReg, stopReg;

  logic                  isIo, isRead, ioData;
  logic [15:0]           ioOff;
  logic [RAM_ADDR_W-1:0] ramAddr;
  logic                  rxEmpty, rxFull, txEmpty, txFull;
  logic                  rxPush, rxPop, txPushReq, txPush, txPop, stopWr, cntRd;
  logic                  unusedAddrHi;

  assign isIo         = (bus.mem_a_in[17:16] == 2'b11);
  assign ioOff        = bus.mem_a_in[15:0];
  assign ramAddr      = bus.mem_a_in[RAM_ADDR_W-1:0];
  assign unusedAddrHi = ^bus.mem_a_in[31:18];
  assign isRead       = !bus.mem_wr_in;
  assign ioData       = isIo && (ioOff == IO_DATA);

  assign rxEmpty = (rxCount == '0);
  assign rxFull  = (rxCount == CNT_W'(FIFO_DEPTH));
  assign txEmpty = (txCount == '0);
  assign txFull  = (txCount == CNT_W'(FIFO_DEPTH));

  // I/O side effects are gated by rdyReg so a frozen CPU repeating its access is harmless.
  assign stopWr    = isIo && (ioOff == IO_CNT0) && bus.mem_wr_in && rdyReg;
  assign cntRd     = isIo && (ioOff == IO_CNT0) && isRead;
  assign rxPop     = ioData && isRead && rdyReg && !rxEmpty;
  assign rxPush    = rx_valid_in && !rxFull;
  assign txPushReq = stopWr || (ioData && bus.mem_wr_in && rdyReg && (bus.mem_dout_in != 8'h00));
  assign txPushData = stopWr ? 8'h00 : bus.mem_dout_in;
  assign txPop     = !txEmpty && tx_ready_in;
  assign txPush    = txPushReq && (!txFull || txPop);

  assign rxCountNext = rxCount + CNT_W'(rxPush) - CNT_W'(rxPop);
  assign txCountNext = txCount + CNT_W'(txPush) - CNT_W'(txPop);

  always_comb begin
    // NOTE: default first so every path assigns readData and no latch is inferred.
    readData = 8'h00;
    if (!isIo) begin
      readData = ram[ramAddr];
    end else begin
      case (ioOff)
        IO_DATA: readData = rxEmpty ? 8'h00 : rxMem[rxRdPtr];
        IO_CNT0: readData = cycleCnt[7:0];
        IO_CNT1: readData = cntSnap[15:8];
        IO_CNT2: readData = cntSnap[23:16];
        IO_CNT3: readData = cntSnap[31:24];
        default: readData = 8'h00;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the reset pointers/counts.
  always_ff @(posedge clk_in) begin
    if (bus.mem_wr_in && !isIo) ram[ramAddr] <= bus.mem_dout_in;
    if (rxPush) rxMem[rxWrPtr] <= rx_data_in;
    if (txPush) txMem[txWrPtr] <= txPushData;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      memDinReg <= 8'h00;
      cycleCnt  <= '0;
      cntSnap   <= '0;
      stopReg   <= 1'b0;
      rdyReg    <= 1'b1;
      rxRdPtr   <= '0;
      rxWrPtr   <= '0;
      txRdPtr   <= '0;
      txWrPtr   <= '0;
      rxCount   <= '0;
      txCount   <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (isRead) memDinReg <= readData;
      if (cntRd)  cntSnap   <= cycleCnt;
      if (stopWr) stopReg   <= 1'b1;
      if (rxPush) rxWrPtr <= rxWrPtr + PTR_W'(1);
      if (rxPop)  rxRdPtr <= rxRdPtr + PTR_W'(1);
      if (txPush) txWrPtr <= txWrPtr + PTR_W'(1);
      if (txPop)  txRdPtr <= txRdPtr + PTR_W'(1);
      rxCount <= rxCountNext;
      txCount <= txCountNext;
      // Freeze while at most one slot remains, so the in-flight access still fits.
      rdyReg  <= (txCountNext <= CNT_W'(FIFO_DEPTH - 2));
    end
  end

  assign bus.mem_din_out = memDinReg;
  assign bus.rdy_out     = rdyReg;
  assign rx_ready_out    = !rxFull;
  assign tx_valid_out    = !txEmpty;
  assign tx_data_out     = txEmpty ? 8'h00 : txMem[txRdPtr];
  assign prog_stop_out   = stopReg;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX/TX FIFOs, counter snapshot,
// stop flag, TX backpressure and asynchronous reset.
module tb_mem_io_responder;
  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] rxData, txData;
  logic       rxValid, rxReady, txValid, txReady, progStop;
  logic [31:0] tbCyc;
  logic [31:0] expCnt;
  logic [7:0]  rdVal;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in        (clk),
    .rst_in        (rstN),
    .bus           (bus),
    .rx_data_in    (rxData),
    .rx_valid_in   (rxValid),
    .rx_ready_out  (rxReady),
    .tx_data_out   (txData),
    .tx_valid_out  (txValid),
    .tx_ready_in   (txReady),
    .prog_stop_out (progStop)
  );

  // Reference cycle count: clocks seen since reset release.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) tbCyc <= 32'd0;
    else       tbCyc <= tbCyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic park();
    bus.mem_a_in    = 32'h0;
    bus.mem_wr_in   = 1'b0;
    bus.mem_dout_in = 8'h00;
  endtask

  task automatic busWr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a_in    = a;
    bus.mem_wr_in   = 1'b1;
    bus.mem_dout_in = d;
    step();
    park();
  endtask

  task automatic busRd(input logic [31:0] a, output logic [7:0] d);
    bus.mem_a_in  = a;
    bus.mem_wr_in = 1'b0;
    step();
    d = bus.mem_din_out;
    park();
  endtask

  task automatic rdCheck(input string tag, input logic [31:0] a, input logic [7:0] exp);
    logic [7:0] d;
    busRd(a, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic drainCheck(input string tag, input int expN, input logic [7:0] expByte);
    int n;
    n = 0;
    txReady = 1'b1;
    for (int i = 0; i < 40 && txValid; i++) begin
      check({tag, "_data"}, {24'h0, txData}, {24'h0, expByte});
      n++;
      step();
    end
    txReady = 1'b0;
    check({tag, "_count"}, n, expN);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    rxData = 8'h00; rxValid = 1'b0; txReady = 1'b0;
    park();
    @(negedge clk);
    @(negedge clk);
    check("rst_din",   {24'h0, bus.mem_din_out}, 32'h0);
    check("rst_rdy",   bus.rdy_out, 1);
    check("rst_rxrdy", rxReady, 1);
    check("rst_txval", txValid, 0);
    check("rst_txdat", {24'h0, txData}, 32'h0);
    check("rst_stop",  progStop, 0);
    rstN = 1'b1;
    step();

    // RAM write/read, read latency and hold
    busWr(32'h0000_0124, 8'h5A);
    busWr(32'h0000_0123, 8'hA5);
    rdCheck("ram_rd123", 32'h0000_0123, 8'hA5);
    busWr(32'h0000_0200, 8'h77);
    check("ram_hold", {24'h0, bus.mem_din_out}, 32'hA5);
    rdCheck("ram_rd124", 32'h0000_0124, 8'h5A);
    rdCheck("ram_rd200", 32'h0000_0200, 8'h77);

    // RX basic
    rxValid = 1'b1; rxData = 8'h41; step();
    rxData = 8'h42; step();
    rxValid = 1'b0;
    check("rx_ready", rxReady, 1);
    rdCheck("rx_pop0", 32'h0003_0000, 8'h41);
    rdCheck("rx_pop1", 32'h0003_0000, 8'h42);
    rdCheck("rx_empty", 32'h0003_0000, 8'h00);
    check("rx_ready2", rxReady, 1);

    // RX fill to full, overflow byte dropped
    rxValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rxData = 8'h10 + 8'(i);
      step();
    end
    check("rx_full_rdy", rxReady, 0);
    rxData = 8'h20; step();
    rxValid = 1'b0;
    for (int i = 0; i < 16; i++) rdCheck("rx_full_pop", 32'h0003_0000, 8'h10 + 8'(i));
    rdCheck("rx_after_full", 32'h0003_0000, 8'h00);
    check("rx_ready3", rxReady, 1);

    // TX backpressure
    for (int i = 0; i < 14; i++) busWr(32'h0003_0000, 8'h61);
    check("tx_rdy14", bus.rdy_out, 1);
    check("tx_val14", txValid, 1);
    check("tx_head14", {24'h0, txData}, 32'h61);
    busWr(32'h0003_0000, 8'h61);
    check("tx_rdy15", bus.rdy_out, 0);
    busWr(32'h0003_0000, 8'h62);
    busWr(32'h0003_0000, 8'h62);
    check("tx_rdy_frozen", bus.rdy_out, 0);
    txReady = 1'b1;
    step();
    check("tx_rdy_back", bus.rdy_out, 1);
    drainCheck("tx_drain", 14, 8'h61);
    check("tx_rdy_drained", bus.rdy_out, 1);

    // Counter snapshot at cycle 1000
    for (int i = 0; i < 2000 && tbCyc < 32'd1000; i++) step();
    expCnt = tbCyc;
    rdCheck("cnt_b0", 32'h0003_0004, expCnt[7:0]);
    rdCheck("cnt_b1", 32'h0003_0005, expCnt[15:8]);
    rdCheck("cnt_b2", 32'h0003_0006, expCnt[23:16]);
    rdCheck("cnt_b3", 32'h0003_0007, expCnt[31:24]);

    // Counter wrap: snapshot taken while pinned at all-ones, later snapshot is small
    force dut.cycleCnt = 32'hFFFF_FFFF;
    bus.mem_a_in = 32'h0003_0004; bus.mem_wr_in = 1'b0;
    step();
    release dut.cycleCnt;
    check("cnt_max_b0", {24'h0, bus.mem_din_out}, 32'hFF);
    park();
    rdCheck("cnt_max_b3", 32'h0003_0007, 8'hFF);
    step();
    busRd(32'h0003_0004, rdVal);
    rdCheck("cnt_wrap_b1", 32'h0003_0005, 8'h00);
    rdCheck("cnt_wrap_b3", 32'h0003_0007, 8'h00);

    // Stop flag, zero-data write and unmapped I/O
    busWr(32'h0003_0004, 8'h99);
    check("stop_set", progStop, 1);
    check("stop_txval", txValid, 1);
    check("stop_txdat", {24'h0, txData}, 32'h0);
    busWr(32'h0003_0000, 8'h00);
    busWr(32'h0003_0010, 8'h33);
    rdCheck("io_other", 32'h0003_0010, 8'h00);
    drainCheck("stop_tx", 1, 8'h00);
    step();
    check("stop_sticky", progStop, 1);

    // Asynchronous reset during TX drain
    rxValid = 1'b1; rxData = 8'h55; step();
    rxValid = 1'b0;
    for (int i = 1; i <= 5; i++) busWr(32'h0003_0000, 8'(i));
    rdCheck("pre_rst_ram", 32'h0000_0123, 8'hA5);
    txReady = 1'b1;
    check("pre_rst_head", {24'h0, txData}, 32'h01);
    #2 rstN = 1'b0;
    #1;
    check("arst_txval", txValid, 0);
    check("arst_txdat", {24'h0, txData}, 32'h0);
    check("arst_rdy",   bus.rdy_out, 1);
    check("arst_stop",  progStop, 0);
    check("arst_din",   {24'h0, bus.mem_din_out}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    txReady = 1'b0;
    step();
    check("post_rst_txval", txValid, 0);
    rdCheck("post_rst_ram", 32'h0000_0123, 8'hA5);
    rdCheck("post_rst_rx", 32'h0003_0000, 8'h00);
    expCnt = tbCyc;
    rdCheck("post_rst_cnt", 32'h0003_0004, expCnt[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
